mem_port_arbiter: RTL

Shares the single memory32 port among three requesters: instruction fetch, data load and data store. Each requester has its own valid/ready request channel and a one-cycle response pulse. The arbiter grants one requester at a time, drives the memory enable/address/data, and waits a fixed memory latency. It then returns read data, or a write acknowledge, to the requester that owns the transaction. It sits in `system` between the processor core's fetch$/memRead/memWrite methods and the memory32 instance.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_pick.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the FSM state enum, the requester id enum and the cyclic
// successor helper used by the round-robin picker.
package mem_arb_pkg;

    localparam int MEM_ARB_NUM_REQ = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_STORE = 2'd2
    } arb_req_id_t;

    // Cyclic successor: fetch -> load -> store -> fetch
    function automatic arb_req_id_t next_req(input arb_req_id_t id);
        case (id)
            REQ_FETCH: next_req = REQ_LOAD;
            REQ_LOAD:  next_req = REQ_STORE;
            default:   next_req = REQ_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational requester picker for the memory port arbiter.
// Default: fixed priority store > load > fetch, pointer ignored.
// MEM_ARB_ROUND_ROBIN_EN: search starts at the requester after the
// last-granted one, in cyclic order fetch -> load -> store.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [MEM_ARB_NUM_REQ-1:0] valid,
    input  arb_req_id_t                last,
    output logic [MEM_ARB_NUM_REQ-1:0] grant,
    output arb_req_id_t                grant_id
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_req_id_t cand;
    logic        found;

    // Walk the three requesters starting after the last grant
    always_comb begin
        grant    = '0;
        grant_id = REQ_FETCH;
        found    = 1'b0;
        cand     = next_req(last);
        for (int k = 0; k < MEM_ARB_NUM_REQ; k++) begin
            if (!found && valid[cand]) begin
                found    = 1'b1;
                grant    = 3'b001 << cand;
                grant_id = cand;
            end
            cand = next_req(cand);
        end
    end
`else
    // Pointer has no meaning under fixed priority
    logic unused_last;
    assign unused_last = ^last;

    // Fixed priority: store first, then load, then fetch
    always_comb begin
        grant    = '0;
        grant_id = REQ_FETCH;
        if (valid[REQ_STORE]) begin
            grant    = 3'b100;
            grant_id = REQ_STORE;
        end else if (valid[REQ_LOAD]) begin
            grant    = 3'b010;
            grant_id = REQ_LOAD;
        end else if (valid[REQ_FETCH]) begin
            grant    = 3'b001;
            grant_id = REQ_FETCH;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory32 port among fetch, load and store requesters.
// One outstanding transaction; response pulses MEM_LAT+1 cycles after
// the grant. Optional macro MEM_ARB_ROUND_ROBIN_EN switches the picker
// from fixed priority to round-robin with a last-grant pointer.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
)
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              fetch_req_valid,
    output logic              fetch_req_ready,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    output logic              fetch_rsp_valid,
    output logic [DATA_W-1:0] fetch_rsp_data,
    input  logic              load_req_valid,
    output logic              load_req_ready,
    input  logic [ADDR_W-1:0] load_req_addr,
    output logic              load_rsp_valid,
    output logic [DATA_W-1:0] load_rsp_data,
    input  logic              store_req_valid,
    output logic              store_req_ready,
    input  logic [ADDR_W-1:0] store_req_addr,
    input  logic [DATA_W-1:0] store_req_data,
    output logic              store_rsp_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = 2;

    arb_state_t                 state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    arb_req_id_t                owner_reg, owner_next;
    arb_req_id_t                last_ptr;
    arb_req_id_t                pick_id;
    logic [MEM_ARB_NUM_REQ-1:0] req_valid;
    logic [MEM_ARB_NUM_REQ-1:0] pick_grant;
    logic [MEM_ARB_NUM_REQ-1:0] req_ready;
    logic                       capture;

    assign req_valid = {store_req_valid, load_req_valid, fetch_req_valid};

    mem_arb_pick u_pick (
        .valid    (req_valid),
        .last     (last_ptr),
        .grant    (pick_grant),
        .grant_id (pick_id)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_req_id_t last_reg;

    // Remember the most recent grant; store after reset so fetch is tried first
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_reg <= REQ_STORE;
        end else if (mem_en) begin
            last_reg <= pick_id;
        end
    end

    assign last_ptr = last_reg;
`else
    assign last_ptr = REQ_STORE;
`endif

    // Next state, counter and owner plus the combinational memory/ready outputs
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        capture    = 1'b0;
        req_ready  = '0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            ARB_IDLE: begin
                // RESET gating keeps readies low while reset is asserted
                if (RESET && (|pick_grant)) begin
                    req_ready  = pick_grant;
                    mem_en     = 1'b1;
                    state_next = ARB_WAIT;
                    cnt_next   = CNT_W'(MEM_LAT - 1);
                    owner_next = pick_id;
                    case (pick_id)
                        REQ_STORE: begin
                            mem_we    = 1'b1;
                            mem_addr  = store_req_addr;
                            mem_wdata = store_req_data;
                        end
                        REQ_LOAD:  mem_addr = load_req_addr;
                        default:   mem_addr = fetch_req_addr;
                    endcase
                end
            end
            ARB_WAIT: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = ARB_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // State, latency counter and owner registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= ARB_IDLE;
            cnt_reg   <= '0;
            owner_reg <= REQ_FETCH;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
        end
    end

    // Per-requester registered response pulse and (for reads) data holder
    genvar gi;
    generate
        for (gi = 0; gi < MEM_ARB_NUM_REQ; gi++) begin : g_rsp
            logic valid_reg;

            // Pulse the owner's response for one cycle after capture
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= capture && (owner_reg == arb_req_id_t'(gi));
                end
            end

            if (gi != int'(REQ_STORE)) begin : g_data
                logic [DATA_W-1:0] data_reg;

                // Capture read data for the owner; hold otherwise
                always_ff @(posedge CLK or negedge RESET) begin
                    if (!RESET) begin
                        data_reg <= '0;
                    end else if (capture && (owner_reg == arb_req_id_t'(gi))) begin
                        data_reg <= mem_rdata;
                    end
                end
            end
        end
    endgenerate

    assign fetch_req_ready = req_ready[REQ_FETCH];
    assign load_req_ready  = req_ready[REQ_LOAD];
    assign store_req_ready = req_ready[REQ_STORE];
    assign fetch_rsp_valid = g_rsp[0].valid_reg;
    assign load_rsp_valid  = g_rsp[1].valid_reg;
    assign store_rsp_valid = g_rsp[2].valid_reg;
    assign fetch_rsp_data  = g_rsp[0].g_data.data_reg;
    assign load_rsp_data   = g_rsp[1].g_data.data_reg;

endmodule
